apb_fb_master: RTL
==================

Name: apb_fb_master

Overview:
APB initiator that drives the Hub75 control/status and frame-buffer APB responder from inside the fabric, for bring-up, test-pattern loading and self-test without the MSS. Accepts one command (read or write, base byte address, beat count) and issues that many sequential single APB transfers. Each transfer advances the address by one 32-bit word. Write data arrives on a valid/ready stream; read data leaves as a one-cycle-valid stream.

Parameters:
ADDR_W, 18, APB byte address width ([17] register space, [16:2] word address)
DATA_W, 32, APB data width
LEN_W, 11, beat-count width (0..1024)
TIMEOUT, 256, ACCESS cycles without pready before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
preset  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  base byte address; bits [1:0] ignored
cmd_len  in  LEN_W  number of beats
wr_valid  in  1  write data present
wr_ready  out  1  write data accepted
wr_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid (single cycle, no backpressure)
rd_data  out  DATA_W  read beat data
busy  out  1  command in progress
done  out  1  one-cycle pulse at command end
err  out  1  sticky error (pslverr or timeout)
psel, penable, pwrite  out  1 each  APB control
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready; tie high for zero-wait responders
pslverr  in  1  APB error; tie low if unused

Behaviour:
- Reset (sync, preset=1 at edge): state IDLE. All outputs 0 except cmd_ready=1; internal address/count 0; err=0. Reset mid-transfer drops psel/penable at that edge; the responder sees an abandoned transfer, which is acceptable.
- States: IDLE, WDATA, SETUP, ACCESS, DONE.
- IDLE: cmd_ready=1, busy=0. On cmd_valid:
  - Latch addr = {cmd_addr[ADDR_W-1:2],2'b00}, remaining = cmd_len, and dir.
  - Clear err.
  - Go to DONE if cmd_len==0, else to WDATA (write) or SETUP (read).
- WDATA: psel=0, wr_ready=1. On wr_valid, latch pwdata=wr_data and go to SETUP. Stalls indefinitely.
- SETUP: exactly one cycle; psel=1, penable=0, paddr=addr, pwrite=dir. Go to ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stay stable until pready.
  - On pready=1 with pslverr=1: set err and go to DONE. Remaining beats are discarded; the read beat is not delivered.
  - On pready=1 with pslverr=0:
    - For reads, the next cycle has rd_data=prdata (registered) and rd_valid=1 for one cycle.
    - addr += 4, wrapping modulo 2^ADDR_W; remaining -= 1.
    - Go to DONE if remaining was 1, else to WDATA (write) or SETUP (read). Read-to-read keeps psel high through SETUP.
  - Timeout counter resets on entering ACCESS. If it reaches TIMEOUT with pready still 0: err=1, deassert psel/penable, go to DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE. rd_valid for the final read beat coincides with done.
- Minimum throughput: read 2 cycles/beat, write 3 cycles/beat with wr_valid held high.
- busy=1 in every state except IDLE. cmd_ready=0 while busy; commands are never queued.
- pwdata holds its last value outside write transfers. paddr holds its last value when psel=0.

Decomposition:
- Shared package hub75_apb_pkg:
  - state enum.
  - APB byte-address constants STATUS_ADDR=18'h20000, CONTROL_ADDR=18'h20004, PPROW_ADDR=18'h20008 (word addresses 0x8000..0x8002).
  - FB_BASE=18'h00000.
  - RGB565/ABGR field positions shared with the responder.
- No sub-module is required. The timeout counter stays inline; it is too small to justify a separate apb_timeout_ctr.

Test Plan:
1. Read STATUS_ADDR, len 1, responder returns 32'hDEADBEEF with pready=1 -> psel high 2 cycles, penable in the 2nd, paddr=0x20000; next cycle rd_valid=1, rd_data=0xDEADBEEF, done=1, err=0.
2. Write len 4 at 0x00000, data 0x00FF0000..0x00FF0003, with wr_valid low 2 cycles before beat 3 -> paddr 0x0/0x4/0x8/0xC with matching pwdata, psel=0 during the stall, exactly 4 ACCESS-with-pready cycles, then done.
3. Read len 1 with pready low for 3 ACCESS cycles -> ACCESS lasts 4 cycles, paddr/pwrite stable throughout, single rd_valid.
4. Write len 4 with pslverr=1 on beat 2 -> exactly 2 transfers, err=1 sticky, done pulse; next cmd acceptance clears err.
5. Read with pready held 0 -> after 256 ACCESS cycles psel=penable=0, err=1, done, no rd_valid.
6. Reset asserted in ACCESS -> psel=penable=0 after that edge, cmd_ready=1 after release. cmd_len=0 -> done the cycle after acceptance, psel never high. Write len 2 at 0x3FFFC -> paddr 0x3FFFC then 0x00000.

Source files
------------

// File: rtl/hub75_apb_pkg.sv
// Shared definitions for the Hub75 APB responder and its in-fabric APB initiator.
// Holds the initiator state encoding, register-map byte addresses and pixel field positions.
package hub75_apb_pkg;

  localparam int unsigned APB_ADDR_W = 18;
  localparam int unsigned APB_DATA_W = 32;

  // Bit 17 of the byte address selects register space over the frame buffer.
  localparam int unsigned REG_SPACE_BIT = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } fbm_state_t;

  localparam logic [APB_ADDR_W-1:0] STATUS_ADDR  = 18'h20000;
  localparam logic [APB_ADDR_W-1:0] CONTROL_ADDR = 18'h20004;
  localparam logic [APB_ADDR_W-1:0] PPROW_ADDR   = 18'h20008;
  localparam logic [APB_ADDR_W-1:0] FB_BASE      = 18'h00000;

  // RGB565 pixel packing in the low half of a frame-buffer word.
  localparam int unsigned RGB565_B_LSB = 0;
  localparam int unsigned RGB565_B_W   = 5;
  localparam int unsigned RGB565_G_LSB = 5;
  localparam int unsigned RGB565_G_W   = 6;
  localparam int unsigned RGB565_R_LSB = 11;
  localparam int unsigned RGB565_R_W   = 5;

  // ABGR8888 pixel packing, one channel per byte.
  localparam int unsigned ABGR_CH_W  = 8;
  localparam int unsigned ABGR_R_LSB = 0;
  localparam int unsigned ABGR_G_LSB = 8;
  localparam int unsigned ABGR_B_LSB = 16;
  localparam int unsigned ABGR_A_LSB = 24;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [10:0]           len;
  } fb_cmd_t;

endpackage

// File: rtl/apb_fb_master.sv
// In-fabric APB initiator: turns one read/write burst command into sequential single
// APB transfers on consecutive words, with streamed write and read data.
module apb_fb_master
  import hub75_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int unsigned     TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TMO_EN    = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  fbm_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_next;
  logic [LEN_W-1:0]  remaining;
  logic              dir;
  logic [TMO_W-1:0]  tmo_cnt;

  // Word increment wraps naturally at the top of the address space.
  assign addr_next = addr + ADDR_W'(4);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      addr      <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      rd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr      <= cmd_addr & WORD_MASK;
            remaining <= cmd_len;
            dir       <= cmd_write;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else if (cmd_write) begin
              wr_ready <= 1'b1;
              state    <= ST_WDATA;
            end else begin
              psel    <= 1'b1;
              penable <= 1'b0;
              pwrite  <= 1'b0;
              paddr   <= cmd_addr & WORD_MASK;
              state   <= ST_SETUP;
            end
          end
        end

        ST_WDATA: begin
          if (wr_valid) begin
            pwdata   <= wr_data;
            wr_ready <= 1'b0;
            psel     <= 1'b1;
            penable  <= 1'b0;
            pwrite   <= 1'b1;
            paddr    <= addr;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable <= 1'b1;
          tmo_cnt <= '0;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              // Error ends the burst; the failing read beat is never delivered.
              err   <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              if (!dir) begin
                rd_valid <= 1'b1;
                rd_data  <= prdata;
              end
              addr      <= addr_next;
              remaining <= remaining - LEN_W'(1);
              if (remaining == LEN_W'(1)) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else if (dir) begin
                wr_ready <= 1'b1;
                state    <= ST_WDATA;
              end else begin
                // Back-to-back reads keep psel asserted into the next setup phase.
                psel  <= 1'b1;
                paddr <= addr_next;
                state <= ST_SETUP;
              end
            end
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            err     <= 1'b1;
            psel    <= 1'b0;
            penable <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
